// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - IF-stage instruction fetch sequencer (optional FETCH_PERF_COUNTERS_EN adds fetch/stall counters)
module fetch_controller #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  branch_taken,
  input  logic [31:0]           branch_target,
  input  logic                  if_ready,
  output logic                  if_valid,
  output logic [31:0]           if_instruction,
  output logic [31:0]           if_pc,
  output logic                  mem_read,
  output logic [ADDR_WIDTH-1:0] mem_address,
  input  logic [31:0]           mem_instruction,
  input  logic                  mem_busywait
`ifdef FETCH_PERF_COUNTERS_EN
  ,
  output logic [31:0]           fetch_count,
  output logic [31:0]           stall_count
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

  state_t                state_q, state_d;
  logic [31:0]           pc_q, pc_d;
  logic                  squash_q, squash_d;
  logic                  mem_read_q, mem_read_d;
  logic [ADDR_WIDTH-1:0] mem_address_q, mem_address_d;
  logic                  if_valid_q, if_valid_d;
  logic [31:0]           if_instruction_q, if_instruction_d;
  logic [31:0]           if_pc_q, if_pc_d;
  logic [31:0]           target_word;
  state_t                resume_state;

  // Redirect targets are word aligned; the low byte-offset bits are discarded.
  assign target_word  = branch_target & 32'hFFFF_FFFC;
  assign resume_state = enable ? S_REQ : S_IDLE;

  // Next-state, PC, squash and registered-output computation.
  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    squash_d         = squash_q;
    if_valid_d       = if_valid_q;
    if_instruction_d = if_instruction_q;
    if_pc_d          = if_pc_q;
    unique case (state_q)
      S_IDLE: begin
        if (branch_taken) pc_d = target_word;
        if (enable) state_d = S_REQ;
      end
      S_REQ: begin
        state_d = S_WAIT;
        // Memory has already sampled this read, so its response must be squashed.
        if (branch_taken) begin
          squash_d = 1'b1;
          pc_d     = target_word;
        end
      end
      S_WAIT: begin
        if (!mem_busywait) begin
          if (squash_q || branch_taken) begin
            squash_d = 1'b0;
            if (branch_taken) pc_d = target_word;
            state_d = resume_state;
          end else begin
            if_instruction_d = mem_instruction;
            if_pc_d          = pc_q;
            if_valid_d       = 1'b1;
            pc_d             = pc_q + 32'd4;
            state_d          = S_HOLD;
          end
        end else if (branch_taken) begin
          squash_d = 1'b1;
          pc_d     = target_word;
        end
      end
      S_HOLD: begin
        // A redirect wins over a simultaneous handshake: the held word is dropped.
        if (branch_taken) begin
          if_valid_d = 1'b0;
          pc_d       = target_word;
          state_d    = resume_state;
        end else if (if_ready) begin
          if_valid_d = 1'b0;
          state_d    = resume_state;
        end
      end
      default: state_d = S_IDLE;
    endcase
    mem_read_d    = (state_d == S_REQ);
    mem_address_d = pc_d[ADDR_WIDTH+1:2];
  end

  // State and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q          <= S_IDLE;
      pc_q             <= RESET_PC;
      squash_q         <= 1'b0;
      mem_read_q       <= 1'b0;
      mem_address_q    <= RESET_PC[ADDR_WIDTH+1:2];
      if_valid_q       <= 1'b0;
      if_instruction_q <= 32'd0;
      if_pc_q          <= 32'd0;
    end else begin
      state_q          <= state_d;
      pc_q             <= pc_d;
      squash_q         <= squash_d;
      mem_read_q       <= mem_read_d;
      mem_address_q    <= mem_address_d;
      if_valid_q       <= if_valid_d;
      if_instruction_q <= if_instruction_d;
      if_pc_q          <= if_pc_d;
    end
  end

  assign if_valid       = if_valid_q;
  assign if_instruction = if_instruction_q;
  assign if_pc          = if_pc_q;
  assign mem_read       = mem_read_q;
  assign mem_address    = mem_address_q;

`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] stall_count_q, stall_count_d;

  // Transfer and stall-cycle counting; both wrap modulo 2^32.
  always_comb begin
    fetch_count_d = fetch_count_q;
    stall_count_d = stall_count_q;
    if ((state_q == S_HOLD) && if_valid_q && if_ready && !branch_taken)
      fetch_count_d = fetch_count_q + 32'd1;
    if (((state_q == S_WAIT) && mem_busywait) || ((state_q == S_HOLD) && !if_ready))
      stall_count_d = stall_count_q + 32'd1;
  end

  // Counter registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_count_q <= 32'd0;
      stall_count_q <= 32'd0;
    end else begin
      fetch_count_q <= fetch_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign fetch_count = fetch_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// tb/tb_fetch_controller.sv - self-checking bench for fetch_controller (FETCH_PERF_COUNTERS_EN optional)
module tb_fetch_controller;
  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        if_ready;
  logic        if_valid;
  logic [31:0] if_instruction;
  logic [31:0] if_pc;
  logic        mem_read;
  logic [4:0]  mem_address;
  logic [31:0] mem_instruction;
  logic        mem_busywait;
`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  int vectors = 0;
  int miscompares = 0;

  // Reference state: program counter, memory image, expected counters.
  logic [31:0] pc_model;
  logic [31:0] mem [32];
  logic [4:0]  lat_addr = 5'd0;
  int          exp_fetches = 0;
  int          exp_stalls = 0;

  always #5 clock = ~clock;

  fetch_controller #(.ADDR_WIDTH(5), .RESET_PC(32'h0000_0000)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .if_ready(if_ready), .if_valid(if_valid),
    .if_instruction(if_instruction), .if_pc(if_pc),
    .mem_read(mem_read), .mem_address(mem_address),
    .mem_instruction(mem_instruction), .mem_busywait(mem_busywait)
`ifdef FETCH_PERF_COUNTERS_EN
    , .fetch_count(fetch_count), .stall_count(stall_count)
`endif
  );

  // Memory: latches the address on each read strobe and returns that word.
  always @(posedge clock) if (mem_read) lat_addr <= mem_address;
  assign mem_instruction = mem[lat_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One fetch starting from the cycle the read is strobed.
  // br: 0 none, 1 redirect while waiting on memory, 2 redirect while holding the word.
  task automatic fetch(input int busy, input int stall, input int br, input logic [31:0] tgt);
    logic [31:0] fpc;
    int coin;
    fpc  = pc_model;
    coin = (busy == 0) ? 1 : int'($urandom_range(0, 1));
    chk("req_rd", {31'd0, mem_read}, 32'd1);
    chk("req_addr", {27'd0, mem_address}, {27'd0, fpc[6:2]});
    step();
    chk("wait_rd", {31'd0, mem_read}, 32'd0);
    chk("wait_vld", {31'd0, if_valid}, 32'd0);
    mem_busywait = (busy > 0);
    for (int i = 0; i < busy; i++) begin
      if (br == 1 && coin == 0 && i == 0) begin
        branch_taken = 1'b1; branch_target = tgt;
      end
      step();
      branch_taken = 1'b0;
      exp_stalls++;
      chk("busy_vld", {31'd0, if_valid}, 32'd0);
      chk("busy_rd", {31'd0, mem_read}, 32'd0);
    end
    mem_busywait = 1'b0;
    if (br == 1 && coin == 1) begin
      branch_taken = 1'b1; branch_target = tgt;
    end
    step();
    branch_taken = 1'b0;
    if (br == 1) begin
      pc_model = tgt & 32'hFFFF_FFFC;
      chk("sq_vld", {31'd0, if_valid}, 32'd0);
      chk("sq_rd", {31'd0, mem_read}, 32'd1);
      return;
    end
    chk("rsp_vld", {31'd0, if_valid}, 32'd1);
    chk("rsp_pc", if_pc, fpc);
    chk("rsp_ins", if_instruction, mem[fpc[6:2]]);
    pc_model = fpc + 32'd4;
    chk("rsp_addr", {27'd0, mem_address}, {27'd0, pc_model[6:2]});
    if (br == 2) begin
      if_ready = 1'b1; branch_taken = 1'b1; branch_target = tgt;
      step();
      branch_taken = 1'b0;
      pc_model = tgt & 32'hFFFF_FFFC;
      chk("hbr_vld", {31'd0, if_valid}, 32'd0);
      chk("hbr_rd", {31'd0, mem_read}, 32'd1);
      return;
    end
    if (stall > 0) if_ready = 1'b0;
    for (int i = 0; i < stall; i++) begin
      step();
      exp_stalls++;
      chk("stl_vld", {31'd0, if_valid}, 32'd1);
      chk("stl_pc", if_pc, fpc);
      chk("stl_ins", if_instruction, mem[fpc[6:2]]);
      chk("stl_rd", {31'd0, mem_read}, 32'd0);
    end
    if_ready = 1'b1;
    step();
    exp_fetches++;
    chk("xfer_vld", {31'd0, if_valid}, 32'd0);
    chk("xfer_rd", {31'd0, mem_read}, {31'd0, enable});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = $urandom;
    reset = 1'b1; enable = 1'b0; branch_taken = 1'b0; branch_target = 32'd0;
    if_ready = 1'b1; mem_busywait = 1'b0; pc_model = 32'h0;
    step(); step();
    chk("rst_vld", {31'd0, if_valid}, 32'd0);
    chk("rst_ins", if_instruction, 32'd0);
    chk("rst_pc", if_pc, 32'd0);
    chk("rst_rd", {31'd0, mem_read}, 32'd0);
    chk("rst_addr", {27'd0, mem_address}, 32'd0);
    reset = 1'b0; enable = 1'b1;
    step();
    // Zero-wait streaming of words 0..3.
    for (int i = 0; i < 4; i++) fetch(0, 0, 0, 32'd0);
    fetch(4, 0, 0, 32'd0);                // busywait for 4 edges at 0x10
    fetch(0, 5, 0, 32'd0);                // decode stall of 5 at 0x14
    fetch(0, 0, 2, 32'h0000_0008);        // redirect in HOLD to 0x08
    fetch(1, 0, 1, 32'h0000_0040);        // 0x08 squashed in WAIT
    fetch(0, 0, 0, 32'd0);                // 0x40 -> word 16
    fetch(0, 0, 2, 32'h0000_0013);        // redirect to 0x13 -> 0x10
    fetch(0, 0, 0, 32'd0);                // 0x10
    fetch(0, 0, 2, 32'h0000_007C);
    fetch(0, 0, 0, 32'd0);                // 0x7C, address wraps to 0
    fetch(2, 1, 0, 32'd0);                // 0x80
    // Randomized fetch/stall/redirect mix.
    for (int n = 0; n < 20; n++) begin
      int br;
      br = int'($urandom_range(0, 5));
      if (br > 2) br = 0;
      fetch(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), br, $urandom);
    end
    // Enable drops mid-fetch; the fetch completes then the block parks.
    step();
    enable = 1'b0;
    step();
    chk("en_vld", {31'd0, if_valid}, 32'd1);
    chk("en_pc", if_pc, pc_model);
    pc_model = pc_model + 32'd4;
    step();
    exp_fetches++;
    for (int i = 0; i < 3; i++) begin
      chk("idle_rd", {31'd0, mem_read}, 32'd0);
      chk("idle_vld", {31'd0, if_valid}, 32'd0);
      step();
    end
    branch_taken = 1'b1; branch_target = 32'h0000_0026;
    step();
    branch_taken = 1'b0;
    pc_model = 32'h0000_0024;
    chk("idle_br_addr", {27'd0, mem_address}, 32'd9);
    chk("idle_br_rd", {31'd0, mem_read}, 32'd0);
    enable = 1'b1;
    step();
    fetch(0, 0, 0, 32'd0);
`ifdef FETCH_PERF_COUNTERS_EN
    chk("fetch_count", fetch_count, exp_fetches);
    chk("stall_count", stall_count, exp_stalls);
`endif
    // Reset while waiting on memory.
    step();
    mem_busywait = 1'b1;
    step();
    reset = 1'b1;
    #1;
    chk("arst_vld", {31'd0, if_valid}, 32'd0);
    chk("arst_ins", if_instruction, 32'd0);
    chk("arst_pc", if_pc, 32'd0);
    chk("arst_rd", {31'd0, mem_read}, 32'd0);
    chk("arst_addr", {27'd0, mem_address}, 32'd0);
    mem_busywait = 1'b0;
    step(); step();
    reset = 1'b0; enable = 1'b0;
    step(); step();
    chk("late_vld", {31'd0, if_valid}, 32'd0);
    chk("late_rd", {31'd0, mem_read}, 32'd0);
`ifdef FETCH_PERF_COUNTERS_EN
    chk("rst_fcount", fetch_count, 32'd0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
